pc_sequencer: RTL

- Fetch-side controller that owns the program counter and sequences instruction fetches.
- Picks the next PC from reset vector, exception vector, jump/branch redirects, stall hold or sequential PC+STEP.
- Drives a single-outstanding req/ack handshake to instruction memory and hands fetched-instruction validity to decode.
- Sits between the IF-stage memory port and the ID/EX redirect logic.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_sequencer_next_pc_mux.sv | 42 ++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the fetch-side PC sequencer.
// Holds the FSM encoding, the redirect-select encoding and the default vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_EXC    = 2'd3
    } sel_t;

    localparam int          DEF_SIZE      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
    localparam int          DEF_STEP      = 4;

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Priority select of the next fetch address: exc > jump > branch > sequential.
// redirect is high whenever anything other than the sequential address wins.
module next_pc_mux
    import pc_seq_pkg::*;
#(
    parameter int              SIZE    = DEF_SIZE,
    parameter logic [SIZE-1:0] EXC_VEC = SIZE'(DEF_EXC_VEC),
    parameter int              STEP    = DEF_STEP
) (
    input  logic            exc,
    input  logic            jump,
    input  logic [SIZE-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [SIZE-1:0] branch_target,
    input  logic [SIZE-1:0] cur_addr,
    output logic [SIZE-1:0] target,
    output logic            redirect
);

    sel_t sel;

    always_comb begin
        sel = SEL_SEQ;
        if (exc)               sel = SEL_EXC;
        else if (jump)         sel = SEL_JUMP;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    // Sequential increment wraps naturally at 2^SIZE.
    always_comb begin
        target = cur_addr + SIZE'(STEP);
        case (sel)
            SEL_EXC:    target = EXC_VEC;
            SEL_JUMP:   target = jump_target;
            SEL_BRANCH: target = branch_target;
            default:    target = cur_addr + SIZE'(STEP);
        endcase
    end

    assign redirect = (sel != SEL_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Owns the program counter and runs a single-outstanding req/ack fetch handshake.
// Redirects flush the presented instruction; an in-flight request is drained first.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              SIZE      = DEF_SIZE,
    parameter logic [SIZE-1:0] RESET_VEC = SIZE'(DEF_RESET_VEC),
    parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(DEF_EXC_VEC),
    parameter int              STEP      = DEF_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            exc,
    input  logic            jump,
    input  logic [SIZE-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [SIZE-1:0] branch_target,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [SIZE-1:0] pc,
    output logic            if_valid,
    output logic            flush
);

    state_t          state, state_n;
    logic [SIZE-1:0] addr_n, pc_n, tgt, tgt_n, mux_target;
    logic            valid_n, redirect, take;

    next_pc_mux #(.SIZE(SIZE), .EXC_VEC(EXC_VEC), .STEP(STEP)) u_mux (
        .exc          (exc),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .cur_addr     (imem_addr),
        .target       (mux_target),
        .redirect     (redirect)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr <= RESET_VEC;
            pc        <= RESET_VEC;
            if_valid  <= 1'b0;
            tgt       <= RESET_VEC;
        end else begin
            imem_addr <= addr_n;
            pc        <= pc_n;
            if_valid  <= valid_n;
            tgt       <= tgt_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = imem_addr;
        pc_n    = pc;
        valid_n = if_valid;
        tgt_n   = tgt;
        case (state)
            BOOT: begin
                state_n = FETCH;
                addr_n  = RESET_VEC;
            end
            FETCH: begin
                if (take) begin
                    valid_n = 1'b0;
                    tgt_n   = mux_target;
                    // Same-cycle ack completes the old request, so retarget now.
                    if (imem_ack) addr_n  = mux_target;
                    else          state_n = DRAIN;
                end else if (imem_ack) begin
                    pc_n    = imem_addr;
                    valid_n = 1'b1;
                    addr_n  = mux_target;
                    state_n = stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (take) begin
                    valid_n = 1'b0;
                    tgt_n   = mux_target;
                    addr_n  = mux_target;
                end
                if (!stall) state_n = FETCH;
            end
            DRAIN: begin
                valid_n = 1'b0;
                if (take) tgt_n = mux_target;
                if (imem_ack) begin
                    addr_n  = take ? mux_target : tgt;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // Redirects in BOOT are dropped: nothing has been fetched yet.
    always_comb begin
        take     = redirect && (state != BOOT);
        flush    = take;
        imem_req = (state == FETCH) || (state == DRAIN);
    end

endmodule
